// File: rtl/gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_sequencer
// Description : Drives the gate input of adsr_envelope. In PASS mode the HW pin
//               or SW gate bit is passed through with one clock of latency. In
//               the other modes a trigger starts a timed sequence of notes:
//               one-shot, repeat_count+1 repeats, or an endless loop. Each
//               repeat starts only after the envelope has released to IDLE.
//               A trigger while busy aborts the sequence cleanly.
// Ports       : clk           system clock
//               rst_n         asynchronous active-low reset
//               hw_gate       gate pin (already synchronised)
//               sw_gate       gate bit from the I2C register
//               trig          one-clock start/abort pulse
//               mode [1:0]    00 PASS, 01 ONESHOT, 10 REPEAT, 11 LOOP
//               hold_time[7:0]    gate-high ticks (0 behaves as 1)
//               gap_time[7:0]     extra low ticks between notes (0 = 1 clock)
//               repeat_count[7:0] REPEAT: notes fired = repeat_count+1
//               env_state[2:0]    envelope state, 3'b000 = IDLE
//               gate_out      registered gate to the envelope
//               busy          sequence in progress
//               done          one-clock pulse at sequence end
//               seq_state[1:0]    S_IDLE/S_HOLD/S_WAIT_REL/S_GAP
//               reps_left[7:0]    notes still to fire (LOOP: 8'hFF)
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hw_gate,
  input  logic       sw_gate,
  input  logic       trig,
  input  logic [1:0] mode,
  input  logic [7:0] hold_time,
  input  logic [7:0] gap_time,
  input  logic [7:0] repeat_count,
  input  logic [2:0] env_state,
  output logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] seq_state,
  output logic [7:0] reps_left
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] c_mode_pass    = 2'b00;
  localparam logic [1:0] c_mode_oneshot = 2'b01;
  localparam logic [1:0] c_mode_repeat  = 2'b10;
  localparam logic [1:0] c_mode_loop    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_REL = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic             r_gate,  w_gate;
  logic             r_done,  w_done;
  logic [7:0]       r_reps,  w_reps;
  logic [PRE_W-1:0] r_pre,   w_pre;
  logic [7:0]       r_ticks, w_ticks;
  logic [1:0]       r_mode,  w_mode;
  logic [7:0]       r_hold,  w_hold;
  logic [7:0]       r_gap,   w_gap;
  logic             r_first, w_first;

  logic w_pre_last;
  logic w_count_done;

  // Hold length of zero is stretched to one tick so a note is never empty.
  function automatic logic [7:0] f_at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  assign w_pre_last   = (r_pre == c_pre_last);
  // Zero loaded ticks (gap_time=0) ends the timed phase after a single clock.
  assign w_count_done = (r_ticks == 8'd0) || ((r_ticks == 8'd1) && w_pre_last);

  always_comb begin
    w_state = r_state;
    w_gate  = r_gate;
    w_done  = 1'b0;
    w_reps  = r_reps;
    w_pre   = r_pre;
    w_ticks = r_ticks;
    w_mode  = r_mode;
    w_hold  = r_hold;
    w_gap   = r_gap;
    w_first = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (mode == c_mode_pass) begin
          w_gate = hw_gate | sw_gate;
        end else if (trig) begin
          // repeat_count lives on in reps_left; no separate shadow needed.
          w_mode  = mode;
          w_hold  = hold_time;
          w_gap   = gap_time;
          case (mode)
            c_mode_repeat: w_reps = repeat_count;
            c_mode_loop:   w_reps = 8'hFF;
            default:       w_reps = 8'd0;
          endcase
          w_gate  = 1'b1;
          w_pre   = '0;
          w_ticks = f_at_least_one(hold_time);
          w_state = S_HOLD;
        end else begin
          w_gate = 1'b0;
        end
      end

      S_HOLD, S_GAP: begin
        if (trig) begin
          w_gate  = 1'b0;
          w_reps  = 8'd0;
          w_mode  = c_mode_oneshot;
          w_first = 1'b1;
          w_state = S_WAIT_REL;
        end else if (w_count_done) begin
          if (r_state == S_HOLD) begin
            w_gate  = 1'b0;
            w_first = 1'b1;
            w_state = S_WAIT_REL;
          end else begin
            w_gate  = 1'b1;
            w_pre   = '0;
            w_ticks = f_at_least_one(r_hold);
            w_state = S_HOLD;
          end
        end else if (w_pre_last) begin
          w_pre   = '0;
          w_ticks = r_ticks - 8'd1;
        end else begin
          w_pre = r_pre + 1'b1;
        end
      end

      S_WAIT_REL: begin
        // An abort here takes effect in the same cycle as the release check.
        if (trig) begin
          w_gate = 1'b0;
          w_reps = 8'd0;
          w_mode = c_mode_oneshot;
        end
        // First cycle after the fall is skipped: the envelope has not yet
        // seen the falling gate and may still report IDLE.
        if (!r_first && (env_state == 3'b000)) begin
          if ((w_reps == 8'd0) && (w_mode != c_mode_loop)) begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end else begin
            if (w_mode != c_mode_loop) begin
              w_reps = w_reps - 8'd1;
            end
            w_pre   = '0;
            w_ticks = r_gap;
            w_state = S_GAP;
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gate  <= 1'b0;
      r_done  <= 1'b0;
      r_reps  <= 8'd0;
      r_pre   <= '0;
      r_ticks <= 8'd0;
      r_mode  <= 2'b00;
      r_hold  <= 8'd0;
      r_gap   <= 8'd0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state;
      r_gate  <= w_gate;
      r_done  <= w_done;
      r_reps  <= w_reps;
      r_pre   <= w_pre;
      r_ticks <= w_ticks;
      r_mode  <= w_mode;
      r_hold  <= w_hold;
      r_gap   <= w_gap;
      r_first <= w_first;
    end
  end

  assign gate_out  = r_gate;
  assign done      = r_done;
  assign reps_left = r_reps;
  assign seq_state = r_state;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
